pipeline_hazard_ctrl: RTL
=========================

# pipeline_hazard_ctrl

Hazard and sequencing controller for the 5-stage pipeline registers (fetch, decode, execute, memory, writeback). Each cycle it computes stall (hold) and flush (bubble) controls for every stage register and the execute-stage forwarding selects. It also holds an instruction in the memory stage for a configurable number of extra cycles to support a multi-cycle data memory.

## Interface
- DATA_WIDTH, 32: datapath width; only used for perf counter width consistency.
- REGISTER_WIDTH, 5: register index width.
- MEM_WAIT_CYCLES, 0: extra cycles a load or store occupies the memory stage. 0 means single-cycle memory. Legal range is 0–15.

- clk  input  1  pipeline clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- rs1_d_i, rs2_d_i  input  REGISTER_WIDTH  source registers in decode.
- rs1_e_i, rs2_e_i, rd_e_i  input  REGISTER_WIDTH  sources and destination in execute.
- result_src_e_i  input  2  execute result source: 00 ALU, 01 memory, 10 pc+4, 11 imm.
- pc_src_e_i  input  1  taken branch or jump resolved in execute.
- rd_m_i  input  REGISTER_WIDTH  memory-stage destination.
- reg_write_m_i  input  1  memory-stage register write.
- result_src_m_i  input  2  memory-stage result source.
- mem_write_m_i  input  1  memory-stage store.
- rd_w_i  input  REGISTER_WIDTH  writeback destination.
- reg_write_w_i  input  1  writeback register write.
- stall_f_o, stall_d_o, stall_e_o, stall_m_o  output  1  hold the PC or the named stage register.
- flush_d_o, flush_e_o, flush_w_o  output  1  load a bubble into the named stage register.
- forward_a_e_o, forward_b_e_o  output  2  ALU operand select: 00 register file, 01 writeback result, 10 memory-stage ALU result.

## Operation
- Definitions:
  - mem_op = mem_write_m_i OR (result_src_m_i == 01).
  - lw_hit = (result_src_e_i == 01) AND rd_e_i != 0 AND (rd_e_i == rs1_d_i OR rd_e_i == rs2_d_i).
- FSM states are RUN and WAIT. A 4-bit counter cnt supports WAIT.
- mem_stall is asserted when either:
  - state is RUN, mem_op is high and MEM_WAIT_CYCLES > 0; or
  - state is WAIT and cnt != 0.
- FSM transitions:
  - RUN with mem_stall: go to WAIT and set cnt to MEM_WAIT_CYCLES-1.
  - WAIT with cnt != 0: decrement cnt and stay in WAIT.
  - WAIT with cnt == 0: go to RUN. The held instruction advances this cycle.
- Priority is mem_stall, then pc_src_e_i, then lw_hit.
  - mem_stall: stall_f, stall_d, stall_e and stall_m are 1; flush_w is 1; flush_d and flush_e are 0.
  - Else pc_src_e_i: flush_d and flush_e are 1; no stalls. lw_hit is ignored.
  - Else lw_hit: stall_f, stall_d and flush_e are 1.
  - Otherwise all stall and flush outputs are 0.
- Forwarding (operand b uses rs2_e_i in place of rs1_e_i):
  - forward_a is 10 if reg_write_m_i AND rd_m_i != 0 AND rd_m_i == rs1_e_i.
  - Otherwise it is 01 if reg_write_w_i AND rd_w_i != 0 AND rd_w_i == rs1_e_i.
  - Otherwise it is 00.
  - The memory stage always has priority over writeback.
- Back-to-back memory ops: a new mem_op reaching the memory stage in RUN immediately starts a new wait.

## Timing
- All control outputs are combinational from the inputs and the registered state/cnt, with zero-cycle latency.
- State and cnt update on the rising edge of clk.
- Reset (rst_n low, asynchronous):
  - state goes to RUN and cnt to 0.
  - All stall_* outputs are 0, flush_d, flush_e and flush_w are 1, and forwards are 00.
  - This holds for the whole of reset.
- Reset asserted mid-WAIT aborts the wait. The first cycle after release is evaluated in RUN.
- With MEM_WAIT_CYCLES = N > 0, a memory op occupies the memory stage for N+1 cycles. stall_m is high for the first N of them.
- mem_stall covers an lw_hit or pc_src_e_i that arrives during a wait. Both are re-evaluated once the wait ends, because the execute register was held.

## Configuration
- PIPE_HAZARD_PERF_EN defined: adds two outputs, stall_cycles_o and flush_cycles_o, both 32 bits.
  - stall_cycles_o increments on every cycle with stall_f_o high.
  - flush_cycles_o increments on every cycle with pc_src_e_i high while mem_stall is low.
  - Both wrap at 2^32 and reset to 0.
- PIPE_HAZARD_PERF_EN undefined: the counters and ports do not exist and the behaviour is otherwise identical.

## Test plan
- Load-use: result_src_e=01, rd_e=5, rs1_d=5, no memory op. Required: stall_f=1, stall_d=1, flush_e=1, for exactly one cycle. With rd_e=0 instead, no stall.
- Branch taken: pc_src_e=1 together with lw_hit. Required: flush_d=1, flush_e=1 and stall_f=0.
- Forwarding:
  - rd_m=rd_w=7, both writing, rs1_e=7: forward_a=10.
  - Same with reg_write_m=0: forward_a=01.
  - Same with rs2_e=0: forward_b=00.
- Memory wait with MEM_WAIT_CYCLES=2, a load in the memory stage. Required: stall_m and flush_w high for 2 cycles and low on the 3rd. A second load then restarts the stall.
- Reset mid-wait with MEM_WAIT_CYCLES=3: pull rst_n low during the 2nd wait cycle. Required: stalls drop to 0 asynchronously and flushes go to 1. After release, a non-memory op gives all controls 0.
- With PIPE_HAZARD_PERF_EN defined: 3 load-use stalls and 2 taken branches give stall_cycles_o=3 and flush_cycles_o=2.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Stall, flush and forwarding control for a 5-stage pipeline.
// The memory stage can be held for MEM_WAIT_CYCLES extra cycles so that a
// multi-cycle data memory can be used.
// Optional build macro: PIPE_HAZARD_PERF_EN adds 32-bit stall/flush cycle
// counters (stall_cycles_o, flush_cycles_o).
module pipeline_hazard_ctrl #(
   parameter int DATA_WIDTH      = 32,
   parameter int REGISTER_WIDTH  = 5,
   parameter int MEM_WAIT_CYCLES = 0
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [REGISTER_WIDTH-1:0] rs1_d_i,
   input  logic [REGISTER_WIDTH-1:0] rs2_d_i,
   input  logic [REGISTER_WIDTH-1:0] rs1_e_i,
   input  logic [REGISTER_WIDTH-1:0] rs2_e_i,
   input  logic [REGISTER_WIDTH-1:0] rd_e_i,
   input  logic [1:0]                result_src_e_i,
   input  logic                      pc_src_e_i,
   input  logic [REGISTER_WIDTH-1:0] rd_m_i,
   input  logic                      reg_write_m_i,
   input  logic [1:0]                result_src_m_i,
   input  logic                      mem_write_m_i,
   input  logic [REGISTER_WIDTH-1:0] rd_w_i,
   input  logic                      reg_write_w_i,
   output logic                      stall_f_o,
   output logic                      stall_d_o,
   output logic                      stall_e_o,
   output logic                      stall_m_o,
   output logic                      flush_d_o,
   output logic                      flush_e_o,
   output logic                      flush_w_o,
   output logic [1:0]                forward_a_e_o,
   output logic [1:0]                forward_b_e_o
`ifdef PIPE_HAZARD_PERF_EN
   ,
   output logic [31:0]               stall_cycles_o,
   output logic [31:0]               flush_cycles_o
`endif
);

   // Reject nonsensical configurations at elaboration time.
   generate
      if (MEM_WAIT_CYCLES < 0 || MEM_WAIT_CYCLES > 15 || DATA_WIDTH < 1) begin : g_bad_param
         $error("pipeline_hazard_ctrl: MEM_WAIT_CYCLES must be 0..15 and DATA_WIDTH >= 1");
      end
   endgenerate

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   localparam bit         MEM_WAIT_EN = (MEM_WAIT_CYCLES > 0);
   // Counter reload; the RUN cycle that starts the wait is the first stall cycle.
   localparam logic [3:0] WAIT_RELOAD = 4'((MEM_WAIT_CYCLES > 0) ? (MEM_WAIT_CYCLES - 1) : 0);
   localparam logic [1:0] RES_MEM     = 2'b01;
   localparam logic [1:0] FWD_RF      = 2'b00;
   localparam logic [1:0] FWD_WB      = 2'b01;
   localparam logic [1:0] FWD_MEM     = 2'b10;

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic       mem_op;
   logic       lw_hit;
   logic       mem_stall;

   // Hazard detection terms from the current stage contents.
   always_comb begin
      mem_op = mem_write_m_i | (result_src_m_i == RES_MEM);
      lw_hit = (result_src_e_i == RES_MEM) && (rd_e_i != '0) &&
               ((rd_e_i == rs1_d_i) || (rd_e_i == rs2_d_i));
   end

   // Memory-wait sequencer: next state, counter and the mem_stall request.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      mem_stall = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (MEM_WAIT_EN && mem_op) begin
               mem_stall = 1'b1;
               state_d   = ST_WAIT;
               cnt_d     = WAIT_RELOAD;
            end
         end
         ST_WAIT: begin
            if (cnt_q != 4'd0) begin
               mem_stall = 1'b1;
               cnt_d     = cnt_q - 4'd1;
            end else begin
               // Held instruction leaves the memory stage this cycle.
               state_d = ST_RUN;
            end
         end
         default: begin
            state_d = ST_RUN;
            cnt_d   = 4'd0;
         end
      endcase
   end

   // Sequencer state register; reset aborts any wait in progress.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_RUN;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Stall/flush priority: reset, memory wait, taken branch, load-use.
   always_comb begin
      stall_f_o = 1'b0;
      stall_d_o = 1'b0;
      stall_e_o = 1'b0;
      stall_m_o = 1'b0;
      flush_d_o = 1'b0;
      flush_e_o = 1'b0;
      flush_w_o = 1'b0;
      if (!rst_n) begin
         // Fill the pipeline with bubbles for as long as reset is held.
         flush_d_o = 1'b1;
         flush_e_o = 1'b1;
         flush_w_o = 1'b1;
      end else if (mem_stall) begin
         // Freeze everything up to memory; writeback sees bubbles meanwhile.
         stall_f_o = 1'b1;
         stall_d_o = 1'b1;
         stall_e_o = 1'b1;
         stall_m_o = 1'b1;
         flush_w_o = 1'b1;
      end else if (pc_src_e_i) begin
         // Squash the wrong-path instructions; a load-use on that path is moot.
         flush_d_o = 1'b1;
         flush_e_o = 1'b1;
      end else if (lw_hit) begin
         // Hold fetch/decode one cycle and send a bubble into execute.
         stall_f_o = 1'b1;
         stall_d_o = 1'b1;
         flush_e_o = 1'b1;
      end
   end

   // Operand forwarding into execute; the younger memory-stage result wins.
   always_comb begin
      forward_a_e_o = FWD_RF;
      forward_b_e_o = FWD_RF;
      if (rst_n) begin
         if (reg_write_m_i && (rd_m_i != '0) && (rd_m_i == rs1_e_i)) begin
            forward_a_e_o = FWD_MEM;
         end else if (reg_write_w_i && (rd_w_i != '0) && (rd_w_i == rs1_e_i)) begin
            forward_a_e_o = FWD_WB;
         end
         if (reg_write_m_i && (rd_m_i != '0) && (rd_m_i == rs2_e_i)) begin
            forward_b_e_o = FWD_MEM;
         end else if (reg_write_w_i && (rd_w_i != '0) && (rd_w_i == rs2_e_i)) begin
            forward_b_e_o = FWD_WB;
         end
      end
   end

`ifdef PIPE_HAZARD_PERF_EN
   logic [31:0] stall_cycles_q, stall_cycles_d;
   logic [31:0] flush_cycles_q, flush_cycles_d;

   // Free-running event counters; they wrap naturally at 2^32.
   always_comb begin
      stall_cycles_d = stall_cycles_q + {31'd0, stall_f_o};
      flush_cycles_d = flush_cycles_q + {31'd0, (pc_src_e_i & ~mem_stall)};
   end

   // Counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cycles_q <= 32'd0;
         flush_cycles_q <= 32'd0;
      end else begin
         stall_cycles_q <= stall_cycles_d;
         flush_cycles_q <= flush_cycles_d;
      end
   end

   assign stall_cycles_o = stall_cycles_q;
   assign flush_cycles_o = flush_cycles_q;
`endif

endmodule
